// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath.
// Shares one memory port between fetch and data access, with a stall watchdog.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       Z,
  input  logic       N,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AS,
  output logic       MW,
  output logic       IL,
  output logic       PI,
  output logic       PL,
  output logic       RW,
  output logic       MB,
  output logic       MD,
  output logic [3:0] FS,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_M1 =
    CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } st_e;

  st_e           state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          expire;

  // Last waiting cycle before the counter would reach MEM_TIMEOUT
  assign expire = (MEM_TIMEOUT != 0) && (cnt_q == TO_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fault_d = fault_q;
    mem_req = 1'b0;
    AS      = 1'b0;
    MW      = 1'b0;
    IL      = 1'b0;
    PI      = 1'b0;
    PL      = 1'b0;
    RW      = 1'b0;
    MB      = 1'b0;
    MD      = 1'b0;
    FS      = 4'h0;
    halted  = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IL      = 1'b1;
          PI      = 1'b1;
          state_d = DECODE;
        end else if (expire) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        unique case (opcode)
          4'h0:       state_d = FETCH;
          4'h9, 4'hA: state_d = MEM;
          4'hE: begin
            state_d = HALT;
            fault_d = 1'b1;
          end
          4'hF:       state_d = HALT;
          default:    state_d = EXEC;
        endcase
      end
      EXEC: begin
        state_d = FETCH;
        unique case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7: begin
            FS = opcode;
            RW = 1'b1;
          end
          4'h8: begin
            FS = 4'h7;
            MB = 1'b1;
            RW = 1'b1;
          end
          4'hB:    PL = Z;
          4'hC:    PL = N;
          4'hD:    PL = 1'b1;
          default: ;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        AS      = 1'b1;
        MW      = (opcode == 4'hA);
        if (mem_ready) begin
          state_d = (opcode == 4'hA) ? FETCH : WB;
        end else if (expire) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        MD      = 1'b1;
        RW      = 1'b1;
        state_d = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer (MEM_TIMEOUT=4).
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       Z, N, mem_ready;
  logic       mem_req, AS, MW, IL, PI, PL;
  logic       RW, MB, MD, halted, fault;
  logic [3:0] FS;
  logic [2:0] state;
  logic [17:0] obs;

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  control_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .Z(Z), .N(N), .mem_ready(mem_ready),
    .mem_req(mem_req), .AS(AS), .MW(MW), .IL(IL),
    .PI(PI), .PL(PL), .RW(RW), .MB(MB), .MD(MD),
    .FS(FS), .halted(halted), .fault(fault),
    .state(state)
  );

  assign obs = {state, mem_req, AS, MW, IL, PI, PL,
                RW, MB, MD, FS, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {req, AS, MW, IL, PI, PL, RW, MB, MD}; hf = {halted, fault}
  function automatic logic [17:0] E(input logic [2:0] st,
                                    input logic [8:0] ctl,
                                    input logic [3:0] fs,
                                    input logic [1:0] hf);
    return {st, ctl, fs, hf};
  endfunction

  localparam logic [17:0] X_IDLE = 18'h0;
  localparam logic [17:0] X_FW   = {3'd1, 9'b100_000_000, 6'h0};
  localparam logic [17:0] X_FR   = {3'd1, 9'b100_110_000, 6'h0};
  localparam logic [17:0] X_DEC  = {3'd2, 15'h0};
  localparam logic [17:0] X_LD   = {3'd4, 9'b110_000_000, 6'h0};
  localparam logic [17:0] X_ST   = {3'd4, 9'b111_000_000, 6'h0};
  localparam logic [17:0] X_WB   = {3'd5, 9'b000_000_101, 6'h0};
  localparam logic [17:0] X_BT   = {3'd3, 9'b000_001_000, 6'h0};
  localparam logic [17:0] X_BN   = {3'd3, 15'h0};

  task automatic check();
    logic [17:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic rdy,
                      input logic z, input logic n,
                      input logic [17:0] exp, input string tag);
    opcode    = op;
    mem_ready = rdy;
    Z         = z;
    N         = n;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    opcode = 4'h0;
    Z = 1'b0;
    N = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(4'h1, 1, 0, 0, X_IDLE, "reset_hold");

    // ADD from reset
    reset = 1'b1;
    step(4'h1, 1, 0, 0, X_IDLE, "add_idle");
    step(4'h1, 1, 0, 0, X_FR, "add_fetch");
    step(4'h1, 1, 0, 0, X_DEC, "add_dec");
    step(4'h1, 1, 0, 0, E(3, 9'b000_000_100, 4'h1, 2'b00), "add_exec");

    // LD with ready on the 4th MEM cycle
    step(4'h9, 1, 0, 0, X_FR, "ld_fetch");
    step(4'h9, 1, 0, 0, X_DEC, "ld_dec");
    for (int i = 0; i < 3; i++)
      step(4'h9, 0, 0, 0, X_LD, "ld_mem_wait");
    step(4'h9, 1, 0, 0, X_LD, "ld_mem_done");
    step(4'h9, 0, 0, 0, X_WB, "ld_wb");

    // Branches
    step(4'hB, 1, 0, 0, X_FR, "brz1_fetch");
    step(4'hB, 1, 0, 0, X_DEC, "brz1_dec");
    step(4'hB, 1, 1, 0, X_BT, "brz_taken");
    step(4'hB, 1, 1, 0, X_FR, "brz2_fetch");
    step(4'hB, 1, 1, 0, X_DEC, "brz2_dec");
    step(4'hB, 1, 0, 1, X_BN, "brz_not_taken");
    step(4'hC, 1, 0, 1, X_FR, "brn_fetch");
    step(4'hC, 1, 0, 1, X_DEC, "brn_dec");
    step(4'hC, 1, 0, 1, X_BT, "brn_taken");

    // LDI and ST
    step(4'h8, 1, 0, 0, X_FR, "ldi_fetch");
    step(4'h8, 1, 0, 0, X_DEC, "ldi_dec");
    step(4'h8, 1, 0, 0, E(3, 9'b000_000_110, 4'h7, 2'b00), "ldi_exec");
    step(4'hA, 1, 0, 0, X_FR, "st_fetch");
    step(4'hA, 1, 0, 0, X_DEC, "st_dec");
    step(4'hA, 1, 0, 0, X_ST, "st_mem");

    // Ready on the last allowed cycle wins
    for (int i = 0; i < 3; i++)
      step(4'h0, 0, 0, 0, X_FW, "wd_edge_wait");
    step(4'h0, 1, 0, 0, X_FR, "wd_edge_ready");
    step(4'h0, 0, 0, 0, X_DEC, "wd_edge_dec");

    // Watchdog expiry in FETCH
    for (int i = 0; i < 4; i++)
      step(4'h0, 0, 0, 0, X_FW, "wd_wait");
    step(4'h0, 1, 0, 0, E(6, 9'h0, 4'h0, 2'b11), "wd_halt");
    step(4'h0, 1, 0, 0, E(6, 9'h0, 4'h0, 2'b11), "wd_halt_hold");

    reset = 1'b0;
    step(4'h0, 1, 0, 0, X_IDLE, "wd_reset");
    reset = 1'b1;

    // HLT holds for 20 cycles
    step(4'hF, 1, 0, 0, X_IDLE, "hlt_idle");
    step(4'hF, 1, 0, 0, X_FR, "hlt_fetch");
    step(4'hF, 1, 0, 0, X_DEC, "hlt_dec");
    for (int i = 0; i < 20; i++)
      step(4'($urandom_range(0, 15)), 1'(i & 1), 1, 1,
           E(6, 9'h0, 4'h0, 2'b10), "hlt_hold");
    reset = 1'b0;
    step(4'hF, 1, 0, 0, X_IDLE, "hlt_reset");
    reset = 1'b1;

    // Illegal opcode
    step(4'hE, 1, 0, 0, X_IDLE, "ill_idle");
    step(4'hE, 1, 0, 0, X_FR, "ill_fetch");
    step(4'hE, 1, 0, 0, X_DEC, "ill_dec");
    step(4'hE, 1, 0, 0, E(6, 9'h0, 4'h0, 2'b11), "ill_halt");
    reset = 1'b0;
    step(4'hE, 1, 0, 0, X_IDLE, "ill_reset");
    reset = 1'b1;

    // Reset mid-store drops the request asynchronously
    step(4'hA, 1, 0, 0, X_IDLE, "ast_idle");
    step(4'hA, 1, 0, 0, X_FR, "ast_fetch");
    step(4'hA, 1, 0, 0, X_DEC, "ast_dec");
    step(4'hA, 0, 0, 0, X_ST, "ast_mem0");
    step(4'hA, 0, 0, 0, X_ST, "ast_mem1");
    #2;
    exp_q.push_back(X_ST);
    tag_q.push_back("ast_mem2");
    check();
    reset = 1'b0;
    #1;
    exp_q.push_back(X_IDLE);
    tag_q.push_back("ast_async_drop");
    check();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(4'hA, 1, 0, 0, X_IDLE, "ast_post_idle");
    step(4'hA, 1, 0, 0, X_FR, "ast_post_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
